// File: rtl/vga_timing_anim.sv
// 640x480@60 VGA raster timing from a 50 MHz clock, plus a frame-synchronous
// sprite animation index that only ever changes on the frame wrap.
module vga_timing_anim #(
  parameter int unsigned H_VISIBLE    = 640,
  parameter int unsigned H_SYNC_START = 656,
  parameter int unsigned H_SYNC_END   = 752,
  parameter int unsigned H_TOTAL      = 800,
  parameter int unsigned V_VISIBLE    = 480,
  parameter int unsigned V_SYNC_START = 490,
  parameter int unsigned V_SYNC_END   = 492,
  parameter int unsigned V_TOTAL      = 525,
  parameter int unsigned ANIM_FRAMES  = 6,
  parameter int unsigned ANIM_PERIOD  = 8
) (
  input  logic       Clk,
  input  logic       Reset_n,
  input  logic       anim_en,
  output logic       vga_clk,
  output logic [9:0] DrawX,
  output logic [9:0] DrawY,
  output logic       hs,
  output logic       vs,
  output logic       blank,
  output logic       frame_tick,
  output logic [2:0] anim_sel
);

  localparam int unsigned CW = 10;
  localparam int unsigned SW = 3;

  logic          vga_clk_q, vga_clk_d;
  logic [CW-1:0] hc_q, hc_d;
  logic [CW-1:0] vc_q, vc_d;
  logic [SW-1:0] fcnt_q, fcnt_d;
  logic [SW-1:0] anim_sel_q, anim_sel_d;
  logic          frame_tick_q, frame_tick_d;

  logic pix_en;
  logic h_end;
  logic v_end;
  logic frame_wrap;

  // Raster counters advance on the Clk edge where vga_clk falls.
  always_comb begin
    pix_en     = vga_clk_q;
    h_end      = (hc_q == CW'(H_TOTAL - 1));
    v_end      = (vc_q == CW'(V_TOTAL - 1));
    frame_wrap = pix_en && h_end && v_end;

    vga_clk_d = ~vga_clk_q;
    hc_d      = hc_q;
    vc_d      = vc_q;
    if (pix_en) begin
      if (h_end) begin
        hc_d = '0;
        vc_d = v_end ? '0 : vc_q + CW'(1);
      end else begin
        hc_d = hc_q + CW'(1);
      end
    end
  end

  // Animation only moves on a frame wrap, so a drawn frame uses one sprite.
  always_comb begin
    frame_tick_d = frame_wrap;
    fcnt_d       = fcnt_q;
    anim_sel_d   = anim_sel_q;
    if (frame_wrap && anim_en) begin
      if (fcnt_q == SW'(ANIM_PERIOD - 1)) begin
        fcnt_d     = '0;
        anim_sel_d = (anim_sel_q == SW'(ANIM_FRAMES - 1)) ? '0 : anim_sel_q + SW'(1);
      end else begin
        fcnt_d = fcnt_q + SW'(1);
      end
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      vga_clk_q    <= 1'b0;
      hc_q         <= '0;
      vc_q         <= '0;
      fcnt_q       <= '0;
      anim_sel_q   <= '0;
      frame_tick_q <= 1'b0;
    end else begin
      vga_clk_q    <= vga_clk_d;
      hc_q         <= hc_d;
      vc_q         <= vc_d;
      fcnt_q       <= fcnt_d;
      anim_sel_q   <= anim_sel_d;
      frame_tick_q <= frame_tick_d;
    end
  end

  // Sync/blank decode straight from the counters keeps them aligned to DrawX/DrawY.
  assign hs    = !((hc_q >= CW'(H_SYNC_START)) && (hc_q < CW'(H_SYNC_END)));
  assign vs    = !((vc_q >= CW'(V_SYNC_START)) && (vc_q < CW'(V_SYNC_END)));
  assign blank = (hc_q < CW'(H_VISIBLE)) && (vc_q < CW'(V_VISIBLE));

  assign vga_clk    = vga_clk_q;
  assign DrawX      = hc_q;
  assign DrawY      = vc_q;
  assign frame_tick = frame_tick_q;
  assign anim_sel   = anim_sel_q;

endmodule
